// File: rtl/csa_pipe_accum.sv
// =============================================================================
// csa_pipe_accum - two-stage 3:2 carry-save adder with optional accumulate
// Revision: 1.0
// =============================================================================
`default_nettype none

module csa_pipe_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = WIDTH + 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c_in,
  input  logic                 mode,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int SW = WIDTH + 1;

  logic [WIDTH-1:0]     maj;
  logic [SW-1:0]        s_next;
  logic [SW-1:0]        c_next;

  logic                 s1_valid;
  logic [SW-1:0]        s1_s;
  logic [SW-1:0]        s1_c;
  logic                 s1_mode;

  logic                 s2_load;
  logic                 in_fire;
  logic [WIDTH+1:0]     cpa;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 ovf_base;

  // 3:2 compression layer
  assign maj    = (a & b) | (a & c_in) | (b & c_in);
  assign s_next = {1'b0, a ^ b ^ c_in};
  assign c_next = {maj, 1'b0};

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_c     <= '0;
      s1_mode  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_s     <= s_next;
        s1_c     <= c_next;
        s1_mode  <= mode;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Clear takes effect before any accumulate landing on the same edge.
  assign cpa      = {1'b0, s1_s} + {1'b0, s1_c};
  assign acc_base = clear ? '0 : acc;
  assign ovf_base = clear ? 1'b0 : overflow;
  assign acc_sum  = {1'b0, acc_base} + (ACC_WIDTH + 1)'(cpa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        if (s1_mode) begin
          sum      <= acc_sum[ACC_WIDTH-1:0];
          acc      <= acc_sum[ACC_WIDTH-1:0];
          overflow <= ovf_base | acc_sum[ACC_WIDTH];
        end else begin
          sum      <= ACC_WIDTH'(cpa);
          acc      <= acc_base;
          overflow <= ovf_base;
        end
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        acc      <= acc_base;
        overflow <= ovf_base;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/csa_pipe_accum.md
# csa_pipe_accum

Parametrised, pipelined three-operand carry-save adder with an optional running-accumulate mode and a valid/ready stream interface. Stage 1 compresses `a`, `b` and `c_in` into sum and carry vectors with a 3:2 carry-save layer. Stage 2 performs the carry-propagate add, either as a standalone three-operand sum or into a wide accumulator. It is the registered, back-pressurable successor to the combinational 8-bit three-operand adder and sits between operand sources and downstream FHE arithmetic stages.

## Interface
Parameters:
- `WIDTH`, 8, operand width in bits (≥ 2).
- `ACC_WIDTH`, `WIDTH+8`, result and accumulator width in bits (≥ `WIDTH+2`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand triple present.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `a`, `b`, `c_in`  in  `WIDTH` each  unsigned operands.
- `mode`  in  1  0 = plain sum, 1 = accumulate. Sampled with the operands.
- `clear`  in  1  synchronous clear of the accumulator and `overflow`.
- `out_valid`  out  1  `sum` valid.
- `out_ready`  in  1  downstream accepts `sum`.
- `sum`  out  `ACC_WIDTH`  result.
- `overflow`  out  1  sticky accumulator wrap flag.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- Stage 1 (S1 register, capacity 1) stores, on transfer:
  - `s = a ^ b ^ c_in`
  - `c = ((a&b)|(a&c_in)|(b&c_in)) << 1`
  - both zero-extended to `WIDTH+1` bits, plus `mode`.
- Stage 2 (output register, capacity 1) loads when S1 is valid and the output register is empty or draining this cycle:
  - `mode=0`: `sum = zext(s + c)`. The exact `a+b+c_in` always fits in `WIDTH+2` bits. The accumulator is untouched.
  - `mode=1`: `acc_next = acc + s + c`, modulo 2^`ACC_WIDTH`. Then `acc <= acc_next` and `sum = acc_next`. If the true sum is ≥ 2^`ACC_WIDTH`, `overflow <= 1`. `overflow` stays set until `clear` or reset.
- `in_ready = !s1_valid || s2_load`, where `s2_load = s1_valid && (!out_valid || out_ready)`. This gives full throughput with no bubble.
- While `out_valid && !out_ready`, `sum` and `out_valid` hold stable.
- `clear`:
  - Sets `acc` to 0 and `overflow` to 0 at the edge.
  - If it coincides with a `mode=1` S2 load, the clear applies first: `acc` and `sum` equal `s + c` of that transaction, and `overflow` reflects only that add.
  - `clear` has no effect on in-flight data or on `mode=0` results.
- Mixed modes interleave freely. `mode=0` transactions neither read nor modify `acc`.

## Timing
- Reset values while `rst_n` is low:
  - `out_valid` = 0
  - `sum` = 0
  - `overflow` = 0
  - `acc` = 0, S1 empty
  - `in_ready` = 1 once S1 is empty, so 1 from the first cycle after deassert
- Latency is 2 cycles: an operand accepted at edge N appears with `out_valid`=1 after edge N+1.
- Throughput is 1 transaction per cycle while `out_ready`=1.
- Maximum occupancy is 2 transactions. With `out_ready` held low, `in_ready` falls after the second accepted triple.
- Reset asserted mid-operation discards S1, the output register and `acc` immediately. Nothing is delivered from before reset.
- `in_ready` depends combinationally on `out_ready`. No path exists from `in_valid` to `in_ready`.

## Test plan
- Plain sum, `WIDTH`=8:
  - a=b=c_in=255, mode 0 -> `sum`=765 (0x2FD) two cycles later, `overflow`=0.
  - 0,0,0 -> 0.
- Accumulate:
  - clear, then four triples (100,100,100) mode 1 -> `sum` = 300, 600, 900, 1200 on consecutive cycles.
  - An interleaved mode-0 (1,2,3) gives 6 and leaves the next accumulate at 1500.
- Overflow, `ACC_WIDTH`=16:
  - 86 × (255,255,255) mode 1 -> 86th `sum` = 65790 mod 65536 = 254, `overflow`=1.
  - `overflow` stays 1 through further adds.
  - `clear` returns `overflow` to 0.
- Clear coincident with a load: clear asserted on the cycle a mode-1 (10,20,30) enters S2, with acc previously 500 -> `sum`=60, acc=60.
- Backpressure:
  - `out_ready`=0 for 5 cycles with `in_valid` constant -> exactly 2 triples accepted, `in_ready`=0 afterwards, `sum` stable.
  - Release -> results emerge in order with no loss or duplication.
- Reset mid-stream: `rst_n` low with 2 transactions in flight -> `out_valid`=0, `sum`=0 and `overflow`=0 immediately. The first post-reset accumulate starts from acc=0.
